// File: rtl/adc_sample_seq.sv
// ADC sample sequencer: tick-triggered 4-phase conversion handshake with level capture,
// peak hold with linear decay, and sticky overrun/timeout flags.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a tick, adc_req low
// S_REQ     | adc_req high, waiting for adc_ack (bounded by TIMEOUT)
// S_RELEASE | sample captured, adc_req low, waiting for adc_ack to drop
// S_UPDATE  | one cycle: publish level, apply peak load
module adc_sample_seq #(
    parameter logic [9:0] HOLD_TICKS = 10'd50,
    parameter logic [9:0] DECAY_STEP = 10'd1,
    parameter logic [9:0] TIMEOUT    = 10'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clr,
    output logic       adc_req,
    input  logic       adc_ack,
    input  logic [9:0] adc_data,
    output logic [9:0] level,
    output logic [9:0] peak,
    output logic       level_valid,
    output logic       overrun,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    localparam logic [9:0] WAIT_LAST = TIMEOUT - 10'd1;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] wait_cnt;
    logic [9:0] hold_cnt;
    logic [9:0] sample;
    logic       capture;
    logic       timeout_hit;
    logic       peak_load;
    logic       decay;

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (adc_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_RELEASE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!adc_ack) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A fresh load takes precedence over the decay of a coincident tick.
    assign peak_load = (state == S_UPDATE) && (sample >= peak);
    assign decay     = tick && !peak_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_req     <= 1'b0;
            wait_cnt    <= 10'd0;
            sample      <= 10'd0;
            level       <= 10'd0;
            level_valid <= 1'b0;
        end else begin
            // Registered so the request line to the converter is glitch-free.
            adc_req     <= (state_nxt == S_REQ);
            level_valid <= (state == S_UPDATE);
            if (state == S_REQ) begin
                wait_cnt <= wait_cnt + 10'd1;
            end else begin
                wait_cnt <= 10'd0;
            end
            if (capture) begin
                sample <= adc_data;
            end
            if (state == S_UPDATE) begin
                level <= sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak     <= 10'd0;
            hold_cnt <= 10'd0;
        end else if (peak_load) begin
            peak     <= sample;
            hold_cnt <= HOLD_TICKS;
        end else if (decay) begin
            if (hold_cnt != 10'd0) begin
                hold_cnt <= hold_cnt - 10'd1;
            end else if (peak > DECAY_STEP) begin
                peak <= peak - DECAY_STEP;
            end else begin
                peak <= 10'd0;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clr) begin
                overrun <= 1'b0;
            end
            if (timeout_hit) begin
                timeout <= 1'b1;
            end else if (clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_seq.sv
// Bench for adc_sample_seq: two parameterisations driven in parallel, checked every cycle
// against a handshake/peak model, plus directed scenarios with literal expectations.
module tb_adc_sample_seq;

    localparam int HT0 = 50;
    localparam int DS0 = 1;
    localparam int HT1 = 3;
    localparam int DS1 = 4;
    localparam int TMO = 255;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       clr;
    logic       adc_ack;
    logic [9:0] adc_data;

    logic       adc_req0, level_valid0, overrun0, timeout0;
    logic [9:0] level0, peak0;
    logic       adc_req1, level_valid1, overrun1, timeout1;
    logic [9:0] level1, peak1;

    int n_checks = 0;
    int n_fail   = 0;

    adc_sample_seq #(.HOLD_TICKS(10'd50), .DECAY_STEP(10'd1), .TIMEOUT(10'd255)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr),
        .adc_req(adc_req0), .adc_ack(adc_ack), .adc_data(adc_data),
        .level(level0), .peak(peak0), .level_valid(level_valid0),
        .overrun(overrun0), .timeout(timeout0)
    );

    adc_sample_seq #(.HOLD_TICKS(10'd3), .DECAY_STEP(10'd4), .TIMEOUT(10'd255)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .clr(clr),
        .adc_req(adc_req1), .adc_ack(adc_ack), .adc_data(adc_data),
        .level(level1), .peak(peak1), .level_valid(level_valid1),
        .overrun(overrun1), .timeout(timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: handshake phase flags, per-instance peak/hold as plain integers.
    bit cmp_on = 1'b0;
    bit m_req, m_rel, m_upd, m_lv, m_ovr, m_tmo;
    int m_waited, m_sample, m_level;
    int m_peak [2];
    int m_hold [2];

    initial begin
        bit busy;
        bit tmo_set;
        int ht;
        int ds;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_req = 0; m_rel = 0; m_upd = 0; m_lv = 0; m_ovr = 0; m_tmo = 0;
                m_waited = 0; m_sample = 0; m_level = 0;
                for (int i = 0; i < 2; i++) begin
                    m_peak[i] = 0;
                    m_hold[i] = 0;
                end
                cmp_on = 1'b1;
            end else begin
                busy = m_req || m_rel || m_upd;
                for (int i = 0; i < 2; i++) begin
                    ht = (i == 0) ? HT0 : HT1;
                    ds = (i == 0) ? DS0 : DS1;
                    if (m_upd && (m_sample >= m_peak[i])) begin
                        m_peak[i] = m_sample;
                        m_hold[i] = ht;
                    end else if (tick) begin
                        if (m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
                        else m_peak[i] = (m_peak[i] > ds) ? m_peak[i] - ds : 0;
                    end
                end
                m_lv = m_upd;
                if (m_upd) m_level = m_sample;
                if (tick && busy) m_ovr = 1;
                else if (clr) m_ovr = 0;
                tmo_set = 0;
                if (!busy) begin
                    if (tick) begin
                        m_req = 1;
                        m_waited = 0;
                    end
                end else if (m_req) begin
                    m_waited = m_waited + 1;
                    if (adc_ack) begin
                        m_sample = int'(adc_data);
                        m_req = 0;
                        m_rel = 1;
                    end else if (m_waited == TMO) begin
                        m_req = 0;
                        tmo_set = 1;
                    end
                end else if (m_rel) begin
                    if (!adc_ack) begin
                        m_rel = 0;
                        m_upd = 1;
                    end
                end else begin
                    m_upd = 0;
                end
                if (tmo_set) m_tmo = 1;
                else if (clr) m_tmo = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check1("adc_req0", adc_req0, m_req);
                check1("adc_req1", adc_req1, m_req);
                check1("level_valid0", level_valid0, m_lv);
                check1("level_valid1", level_valid1, m_lv);
                check10("level0", level0, 10'(m_level));
                check10("level1", level1, 10'(m_level));
                check10("peak0", peak0, 10'(m_peak[0]));
                check10("peak1", peak1, 10'(m_peak[1]));
                check1("overrun0", overrun0, m_ovr);
                check1("overrun1", overrun1, m_ovr);
                check1("timeout0", timeout0, m_tmo);
                check1("timeout1", timeout1, m_tmo);
            end
        end
    end

    // Tick, ack in the first REQ cycle, ack low in the first RELEASE cycle.
    task automatic txn(input logic [9:0] d, output logic [4:0] lv_tr, output logic [4:0] req_tr);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        lv_tr[0] = level_valid0; req_tr[0] = adc_req0;
        adc_ack = 1'b1; adc_data = d;
        @(negedge clk); adc_ack = 1'b0;
        lv_tr[1] = level_valid0; req_tr[1] = adc_req0;
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            lv_tr[k] = level_valid0; req_tr[k] = adc_req0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        logic [4:0] lv_tr;
        logic [4:0] req_tr;
        int cnt;
        int lvc;
        bit req_seen;
        bit noack;
        int dly;
        int hold_r;

        rst = 1'b1; tick = 1'b0; clr = 1'b0; adc_ack = 1'b0; adc_data = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check1("reset adc_req", adc_req0, 1'b0);
        check10("reset level", level0, 10'd0);
        check10("reset peak", peak0, 10'd0);
        check1("reset level_valid", level_valid0, 1'b0);
        check1("reset overrun", overrun0, 1'b0);
        check1("reset timeout", timeout0, 1'b0);

        // Basic conversion: latency and single pulse.
        txn(10'd300, lv_tr, req_tr);
        check10("basic lv trace", {5'd0, lv_tr}, 10'b0000001000);
        check10("basic req trace", {5'd0, req_tr}, 10'b0000000001);
        check10("basic level", level0, 10'd300);
        check10("basic peak0", peak0, 10'd300);
        check10("basic peak1", peak1, 10'd300);

        // Peak hold then decay with smaller samples.
        for (int k = 1; k <= 52; k++) begin
            txn(10'd100, lv_tr, req_tr);
            if (k == 50) begin
                check10("hold peak0 k50", peak0, 10'd300);
                check10("decay peak1 k50", peak1, 10'd112);
            end
            if (k == 51) begin
                check10("decay peak0 k51", peak0, 10'd299);
                check10("decay peak1 k51", peak1, 10'd108);
            end
            if (k == 52) begin
                check10("decay peak0 k52", peak0, 10'd298);
                check10("decay peak1 k52", peak1, 10'd104);
                check10("decay level", level0, 10'd100);
            end
        end

        // Decay saturates at zero.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        txn(10'd1, lv_tr, req_tr);
        for (int k = 0; k < 3; k++) txn(10'd0, lv_tr, req_tr);
        check10("sat peak1 held", peak1, 10'd1);
        txn(10'd0, lv_tr, req_tr);
        check10("sat peak1 zero", peak1, 10'd0);
        txn(10'd0, lv_tr, req_tr);
        txn(10'd0, lv_tr, req_tr);
        check10("sat peak1 stays", peak1, 10'd0);
        check10("sat peak0 held", peak0, 10'd1);

        // Timeout when ack never comes.
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        cnt = 0; lvc = 0;
        for (int i = 0; i < 300 && adc_req0; i++) begin
            cnt++;
            lvc += int'(level_valid0);
            @(negedge clk);
        end
        check10("timeout req cycles", 10'(cnt), 10'd255);
        check1("timeout flag", timeout0, 1'b1);
        check10("timeout no lv", 10'(lvc), 10'd0);
        check1("timeout lv after", level_valid0, 1'b0);
        pulse_clr();
        check1("timeout cleared", timeout0, 1'b0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        check1("timeout new req", adc_req0, 1'b1);
        adc_ack = 1'b1; adc_data = 10'd7;
        @(negedge clk); adc_ack = 1'b0;
        repeat (4) @(negedge clk);

        // Overrun: tick during RELEASE with ack held high.
        pulse_clr();
        check1("overrun clear", overrun0, 1'b0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0; adc_ack = 1'b1; adc_data = 10'd500;
        lvc = int'(level_valid0);
        @(negedge clk); tick = 1'b1;
        lvc += int'(level_valid0);
        @(negedge clk); tick = 1'b0;
        lvc += int'(level_valid0);
        check1("overrun set", overrun0, 1'b1);
        @(negedge clk); adc_ack = 1'b0;
        lvc += int'(level_valid0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lvc += int'(level_valid0);
        end
        check10("overrun one lv", 10'(lvc), 10'd1);
        pulse_clr();
        check1("overrun clear2", overrun0, 1'b0);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); tick = 1'b0; clr = 1'b0;
        check1("overrun set beats clr", overrun0, 1'b1);
        adc_ack = 1'b1; adc_data = 10'd20;
        @(negedge clk); adc_ack = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-handshake.
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        check1("midrst req before", adc_req0, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check1("midrst adc_req", adc_req0, 1'b0);
        check10("midrst level", level0, 10'd0);
        check10("midrst peak", peak0, 10'd0);
        check1("midrst level_valid", level_valid0, 1'b0);
        check1("midrst overrun", overrun0, 1'b0);
        check1("midrst timeout", timeout0, 1'b0);

        // Randomised traffic with a behavioural converter.
        req_seen = 0; noack = 0; dly = 0; hold_r = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tick = ($urandom_range(0, 5) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            if (adc_req0 && !adc_ack) begin
                if (!req_seen) begin
                    req_seen = 1;
                    dly      = int'($urandom_range(0, 3));
                    noack    = ($urandom_range(0, 39) == 0);
                    hold_r   = int'($urandom_range(0, 3));
                end
                if (!noack) begin
                    if (dly == 0) begin
                        adc_ack  = 1'b1;
                        adc_data = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15))
                                                               : 10'($urandom_range(0, 1023));
                    end else begin
                        dly--;
                    end
                end
            end else if (adc_ack && !adc_req0) begin
                if (hold_r == 0) adc_ack = 1'b0;
                else hold_r--;
            end
            if (!adc_req0 && !adc_ack) req_seen = 0;
        end

        @(negedge clk);
        tick = 1'b0; clr = 1'b0; rst = 1'b0; adc_ack = 1'b0;
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_seq.md
ADC_SAMPLE_SEQ -- requirements
Module: adc_sample_seq

Interface
REQ-001 Parameter HOLD_TICKS, default 10'd50, ticks peak is held before decay starts.
REQ-002 Parameter DECAY_STEP, default 10'd1, amount subtracted from peak per tick once hold expires.
REQ-003 Parameter TIMEOUT, default 10'd255, max cycles in REQ awaiting adc_ack.
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle sample strobe from the clock divider (dclk).
REQ-007 clr  input  1  one-cycle pulse clearing sticky flags.
REQ-008 adc_req  output  1  conversion request, 4-phase handshake.
REQ-009 adc_ack  input  1  converter acknowledge; adc_data valid while high.
REQ-010 adc_data  input  10  converter result.
REQ-011 level  output  10  last captured sample, registered.
REQ-012 peak  output  10  peak-hold value with decay, registered.
REQ-013 level_valid  output  1  one-cycle pulse when level/peak updated from a new sample.
REQ-014 overrun  output  1  sticky: tick arrived while not IDLE.
REQ-015 timeout  output  1  sticky: ack not received within TIMEOUT cycles.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RELEASE, UPDATE.
REQ-017 IDLE: tick=1 -> REQ; adc_req=1 from the next cycle; wait counter loads 0.
REQ-018 REQ: adc_req=1; adc_ack=1 sampled -> capture adc_data into internal sample reg, go RELEASE.
REQ-019 REQ: wait counter increments each cycle without ack; counter reaching TIMEOUT-1 with ack=0 -> IDLE, adc_req=0 next cycle, timeout set, no level_valid.
REQ-020 RELEASE: adc_req=0; stay while adc_ack=1; adc_ack=0 -> UPDATE.
REQ-021 UPDATE: one cycle; level<=sample, level_valid=1 next cycle, peak logic applied; -> IDLE.
REQ-022 Tick-to-level_valid latency with ack in first REQ cycle and ack low in first RELEASE cycle: 4 cycles.
REQ-023 Peak update in UPDATE: sample >= peak -> peak<=sample, hold counter<=HOLD_TICKS.
REQ-024 Decay on every tick not coinciding with a REQ-023 load: hold counter != 0 -> decrement; else peak<=peak-DECAY_STEP if peak > DECAY_STEP, else 0 (no wrap below 0).
REQ-025 Tick and UPDATE with sample < peak in same cycle: decay step of REQ-024 applies.
REQ-026 tick while state != IDLE: tick dropped, overrun set; FSM unaffected.
REQ-027 clr=1 clears overrun and timeout; set and clr in same cycle: set wins.
REQ-028 All arithmetic 10-bit unsigned; no output wraps.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, adc_req=0, level=0, peak=0, level_valid=0, overrun=0, timeout=0, hold and wait counters 0.
REQ-030 rst overrides all other inputs, including mid-handshake; adc_req low the cycle after rst.

Verification
REQ-031 tick; ack=1 with adc_data=10'd300 one cycle after req rises; ack low next cycle -> req drops, level=300, peak=300, level_valid single pulse 4 cycles after tick.
REQ-032 peak=300, HOLD_TICKS=50, DECAY_STEP=1, then samples 100 -> peak stays 300 for 50 ticks, then 299, 298 on subsequent ticks; level=100.
REQ-033 peak=1, DECAY_STEP=4, hold expired, tick -> peak=0; further ticks keep 0.
REQ-034 tick, ack never asserted -> after 255 cycles req falls, timeout=1, no level_valid; clr -> timeout=0; next tick starts new request.
REQ-035 second tick during RELEASE (ack held high) -> overrun=1, only one level_valid pulse; clr with simultaneous overrun tick -> overrun stays 1.
REQ-036 rst asserted during REQ with adc_req=1 -> next cycle adc_req=0, all outputs 0, state IDLE.
